ca_gen_scheduler: RTL and testbench

- Sequences generation of a 1-D elementary cellular automaton into the row-addressed image memory that the VGA pixel path reads with row = y[9:3] and col = x[9:3].
- On reset or restart: clears all rows, writes a single-cell seed row, then appends one new generation every FRAMES_PER_GEN frames.
- Memory writes happen only during blanking, so display reads are never disturbed.
- Sits between the frame timing generator and the image memory write port.

---
 rtl/ca_gen_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ca_gen_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_gen_scheduler.sv
// rtl/ca_gen_scheduler.sv - elementary cellular automaton generation scheduler
// Clears the image rows, seeds one cell, then writes a new generation every FRAMES_PER_GEN frames during blanking.
module ca_gen_scheduler #(
   parameter int WIDTH          = 80,
   parameter int ROWS           = 60,
   parameter int ROW_BITS       = 7,
   parameter int FRAMES_PER_GEN = 4,
   parameter int WRAP           = 1,
   parameter int SEED_COL       = WIDTH / 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                frame_tick,
   input  logic                blank,
   input  logic [7:0]          rule,
   input  logic                restart,
   output logic                wr_en,
   output logic [ROW_BITS-1:0] wr_row,
   output logic [WIDTH-1:0]    wr_data,
   output logic                busy,
   output logic [15:0]         gen_count
);

   localparam int FC_BITS = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
   localparam logic [FC_BITS-1:0]  FC_LAST  = FC_BITS'(FRAMES_PER_GEN - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
   localparam logic [WIDTH-1:0]    SEED_ROW = {{(WIDTH-1){1'b0}}, 1'b1} << SEED_COL;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_SEED,
      S_IDLE,
      S_COMPUTE,
      S_WRITE
   } state_t;

   state_t              state, state_d;
   logic [ROW_BITS-1:0] clr_ptr, clr_ptr_d;
   logic [ROW_BITS-1:0] wr_ptr, wr_ptr_d;
   logic [FC_BITS-1:0]  frame_cnt, frame_cnt_d;
   logic [WIDTH-1:0]    cur, cur_d;
   logic [WIDTH-1:0]    nxt, nxt_d;
   logic [15:0]         gen_count_d;
   logic                wr_en_d;
   logic [ROW_BITS-1:0] wr_row_d;
   logic [WIDTH-1:0]    wr_data_d;
   logic                busy_d;

   // ext[0] is the left neighbour of column 0, ext[WIDTH+1] the right neighbour of the last column
   logic [WIDTH+1:0]    ext;
   logic [WIDTH-1:0]    gen_row;

   always_comb begin
      ext     = {(WRAP != 0) ? cur[0] : 1'b0, cur, (WRAP != 0) ? cur[WIDTH-1] : 1'b0};
      gen_row = '0;
      for (int c = 0; c < WIDTH; c++) begin
         gen_row[c] = rule[{ext[c], ext[c+1], ext[c+2]}];
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_CLEAR;
         clr_ptr   <= '0;
         wr_ptr    <= '0;
         frame_cnt <= '0;
         cur       <= '0;
         nxt       <= '0;
         gen_count <= '0;
         wr_en     <= 1'b0;
         wr_row    <= '0;
         wr_data   <= '0;
         busy      <= 1'b1;
      end else begin
         state     <= state_d;
         clr_ptr   <= clr_ptr_d;
         wr_ptr    <= wr_ptr_d;
         frame_cnt <= frame_cnt_d;
         cur       <= cur_d;
         nxt       <= nxt_d;
         gen_count <= gen_count_d;
         wr_en     <= wr_en_d;
         wr_row    <= wr_row_d;
         wr_data   <= wr_data_d;
         busy      <= busy_d;
      end
   end

   always_comb begin
      state_d     = state;
      clr_ptr_d   = clr_ptr;
      wr_ptr_d    = wr_ptr;
      frame_cnt_d = frame_cnt;
      cur_d       = cur;
      nxt_d       = nxt;
      gen_count_d = gen_count;
      wr_en_d     = 1'b0;
      wr_row_d    = wr_row;
      wr_data_d   = wr_data;

      // restart outranks any tick or write that lands in the same cycle
      if (restart) begin
         state_d     = S_CLEAR;
         clr_ptr_d   = '0;
         wr_ptr_d    = '0;
         frame_cnt_d = '0;
         cur_d       = '0;
         nxt_d       = '0;
         gen_count_d = '0;
         wr_row_d    = '0;
         wr_data_d   = '0;
      end else begin
         case (state)
            S_CLEAR: begin
               if (blank) begin
                  wr_en_d   = 1'b1;
                  wr_row_d  = clr_ptr;
                  wr_data_d = '0;
                  if (clr_ptr == ROW_LAST) begin
                     clr_ptr_d = '0;
                     state_d   = S_SEED;
                  end else begin
                     clr_ptr_d = clr_ptr + 1'b1;
                  end
               end
            end
            S_SEED: begin
               cur_d = SEED_ROW;
               if (blank) begin
                  wr_en_d     = 1'b1;
                  wr_row_d    = '0;
                  wr_data_d   = SEED_ROW;
                  wr_ptr_d    = ROW_BITS'(1);
                  gen_count_d = '0;
                  frame_cnt_d = '0;
                  state_d     = S_IDLE;
               end
            end
            S_IDLE: begin
               if (frame_tick) begin
                  if (frame_cnt == FC_LAST) begin
                     frame_cnt_d = '0;
                     state_d     = S_COMPUTE;
                  end else begin
                     frame_cnt_d = frame_cnt + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               nxt_d   = gen_row;
               state_d = S_WRITE;
            end
            S_WRITE: begin
               if (blank) begin
                  wr_en_d     = 1'b1;
                  wr_row_d    = wr_ptr;
                  wr_data_d   = nxt;
                  cur_d       = nxt;
                  gen_count_d = gen_count + 16'd1;
                  wr_ptr_d    = (wr_ptr == ROW_LAST) ? '0 : wr_ptr + 1'b1;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_CLEAR;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_ca_gen_scheduler.sv
// tb/tb_ca_gen_scheduler.sv - scoreboard bench for ca_gen_scheduler
// Main instance is scoreboarded; side instances cover wrap modes, seed override and frame counting.
module tb_ca_gen_scheduler;

   localparam int W  = 80;
   localparam int R  = 60;
   localparam int RB = 7;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] SEED = ONE << 40;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic frame_tick = 1'b0;
   logic blank = 1'b1;
   logic restart = 1'b0;
   logic [7:0] rule = 8'h5A;

   logic a_wr_en, b_wr_en, c_wr_en, d_wr_en;
   logic [RB-1:0] a_wr_row, b_wr_row, c_wr_row, d_wr_row;
   logic [W-1:0] a_wr_data, b_wr_data, c_wr_data, d_wr_data;
   logic a_busy, b_busy, c_busy, d_busy;
   logic [15:0] a_gen_count, b_gen_count, c_gen_count, d_gen_count;

   ca_gen_scheduler #(.FRAMES_PER_GEN(1), .WRAP(1)) u_a (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .blank(blank), .rule(rule), .restart(restart),
      .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_data(a_wr_data), .busy(a_busy), .gen_count(a_gen_count));
   ca_gen_scheduler #(.FRAMES_PER_GEN(1), .WRAP(1), .SEED_COL(0)) u_b (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .blank(blank), .rule(rule), .restart(restart),
      .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_data(b_wr_data), .busy(b_busy), .gen_count(b_gen_count));
   ca_gen_scheduler #(.FRAMES_PER_GEN(1), .WRAP(0), .SEED_COL(0)) u_c (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .blank(blank), .rule(rule), .restart(restart),
      .wr_en(c_wr_en), .wr_row(c_wr_row), .wr_data(c_wr_data), .busy(c_busy), .gen_count(c_gen_count));
   ca_gen_scheduler #(.FRAMES_PER_GEN(4)) u_d (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .blank(blank), .rule(rule), .restart(restart),
      .wr_en(d_wr_en), .wr_row(d_wr_row), .wr_data(d_wr_data), .busy(d_busy), .gen_count(d_gen_count));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [RB-1:0] row;
      logic [W-1:0]  data;
   } wr_t;

   wr_t sb_q[$];
   wr_t sb_exp;
   int total = 0;
   int bad = 0;
   logic [W-1:0] m_cur = SEED;
   int m_row = 1;
   int m_gen = 0;

   function automatic logic [W-1:0] ca_model(input logic [W-1:0] s, input logic [7:0] r);
      logic [W-1:0] o;
      for (int c = 0; c < W; c++) begin
         o[c] = r[{s[(c + W - 1) % W], s[c], s[(c + 1) % W]}];
      end
      return o;
   endfunction

   always @(negedge clk) begin
      if (a_wr_en === 1'b1) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_write row=%0d data=%h (no write expected)", a_wr_row, a_wr_data);
         end else begin
            sb_exp = sb_q.pop_front();
            if ({a_wr_row, a_wr_data} !== {sb_exp.row, sb_exp.data}) begin
               bad++;
               $display("FAIL sb_write got row=%0d data=%h want row=%0d data=%h",
                        a_wr_row, a_wr_data, sb_exp.row, sb_exp.data);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic push_wr(input int r, input logic [W-1:0] d);
      sb_q.push_back({RB'(r), d});
   endtask

   task automatic push_clear_seed();
      for (int r = 0; r < R; r++) push_wr(r, '0);
      push_wr(0, SEED);
      m_cur = SEED;
      m_row = 1;
      m_gen = 0;
   endtask

   task automatic do_gen();
      logic [W-1:0] n;
      n = ca_model(m_cur, rule);
      push_wr(m_row, n);
      m_cur = n;
      m_row = (m_row + 1) % R;
      m_gen++;
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(3);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (a_busy !== 1'b0 && n < 300);
      total++;
      if (n != 61) begin
         bad++;
         $display("FAIL %s_clear_seed_cycles got=%0d want=61", name, n);
      end
      total++;
      if (sb_q.size() != 0 || a_gen_count !== 16'd0) begin
         bad++;
         $display("FAIL %s_after_seed pending=%0d gen_count=%0d want pending=0 gen_count=0",
                  name, sb_q.size(), a_gen_count);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      blank = 1'b1;
      rule = 8'h5A;
      cyc(2);
      total++;
      if ({a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count} !== {1'b0, 1'b1, {RB{1'b0}}, {W{1'b0}}, 16'd0}) begin
         bad++;
         $display("FAIL reset_outputs got wr_en=%b busy=%b row=%0d data=%h gen=%0d want 0 1 0 0 0",
                  a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count);
      end
      push_clear_seed();
      resetn = 1'b1;
      wait_idle("reset");
   endtask

   task automatic test_gen_latency();
      rule = 8'd90;
      push_wr(1, (ONE << 39) | (ONE << 41));
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      total++;
      if (a_wr_en !== 1'b0) begin
         bad++;
         $display("FAIL latency_edge1 wr_en got=%b want=0", a_wr_en);
      end
      cyc(1);
      total++;
      if (a_wr_en !== 1'b0) begin
         bad++;
         $display("FAIL latency_edge2 wr_en got=%b want=0", a_wr_en);
      end
      cyc(1);
      total++;
      if (a_wr_en !== 1'b1 || a_gen_count !== 16'd1) begin
         bad++;
         $display("FAIL latency_edge3 wr_en=%b gen=%0d want wr_en=1 gen=1", a_wr_en, a_gen_count);
      end
      total++;
      if ({b_wr_en, b_wr_data} !== {1'b1, (ONE << 1) | (ONE << 79)}) begin
         bad++;
         $display("FAIL wrap1_edge wr_en=%b data=%h want 1 bits 1,79", b_wr_en, b_wr_data);
      end
      total++;
      if ({c_wr_en, c_wr_data} !== {1'b1, ONE << 1}) begin
         bad++;
         $display("FAIL wrap0_edge wr_en=%b data=%h want 1 bit 1", c_wr_en, c_wr_data);
      end
      push_wr(2, (ONE << 38) | (ONE << 42));
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(3);
      m_cur = (ONE << 38) | (ONE << 42);
      m_row = 3;
      m_gen = 2;
      total++;
      if (a_gen_count !== 16'd2 || sb_q.size() != 0) begin
         bad++;
         $display("FAIL second_gen gen=%0d pending=%0d want gen=2 pending=0", a_gen_count, sb_q.size());
      end
   endtask

   task automatic test_frame_count();
      do_gen();
      total++;
      if (d_gen_count !== 16'd0 || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL fpg4_tick3 gen=%0d busy=%b want gen=0 busy=0", d_gen_count, d_busy);
      end
      do_gen();
      total++;
      if ({d_gen_count, d_wr_row, d_wr_data} !== {16'd1, RB'(1), ca_model(SEED, rule)}) begin
         bad++;
         $display("FAIL fpg4_tick4 gen=%0d row=%0d data=%h want gen=1 row=1 data=%h",
                  d_gen_count, d_wr_row, d_wr_data, ca_model(SEED, rule));
      end
   endtask

   task automatic test_blank_stall();
      int seen;
      logic [W-1:0] n;
      rule = 8'd30;
      blank = 1'b0;
      n = ca_model(m_cur, rule);
      push_wr(m_row, n);
      m_cur = n;
      m_row = (m_row + 1) % R;
      m_gen++;
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         if (a_wr_en === 1'b1) seen++;
         frame_tick = (i % 10 == 5);
      end
      frame_tick = 1'b0;
      total++;
      if (seen != 0) begin
         bad++;
         $display("FAIL stall_no_write got=%0d writes want=0", seen);
      end
      blank = 1'b1;
      cyc(1);
      total++;
      if (a_wr_en !== 1'b1) begin
         bad++;
         $display("FAIL stall_release wr_en got=%b want=1", a_wr_en);
      end
      cyc(20);
      total++;
      if (a_gen_count !== 16'(m_gen) || sb_q.size() != 0) begin
         bad++;
         $display("FAIL stall_ticks_ignored gen=%0d pending=%0d want gen=%0d pending=0",
                  a_gen_count, sb_q.size(), m_gen);
      end
   endtask

   task automatic test_row_wrap();
      while (m_gen < R) begin
         rule = 8'($urandom_range(0, 255));
         do_gen();
      end
      total++;
      if ({a_wr_row, a_gen_count} !== {RB'(0), 16'(R)} || sb_q.size() != 0) begin
         bad++;
         $display("FAIL row_wrap row=%0d gen=%0d pending=%0d want row=0 gen=%0d pending=0",
                  a_wr_row, a_gen_count, sb_q.size(), R);
      end
   endtask

   task automatic test_restart();
      rule = 8'd90;
      push_clear_seed();
      frame_tick = 1'b1;
      restart = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      restart = 1'b0;
      total++;
      if ({a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count} !== {1'b0, 1'b1, {RB{1'b0}}, {W{1'b0}}, 16'd0}) begin
         bad++;
         $display("FAIL restart_outputs got wr_en=%b busy=%b row=%0d data=%h gen=%0d want 0 1 0 0 0",
                  a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count);
      end
      wait_idle("restart");
   endtask

   task automatic test_async_reset();
      for (int r = 0; r < 30; r++) push_wr(r, '0);
      restart = 1'b1;
      cyc(1);
      restart = 1'b0;
      cyc(30);
      total++;
      if ({a_wr_en, a_wr_row} !== {1'b1, RB'(29)}) begin
         bad++;
         $display("FAIL mid_clear wr_en=%b row=%0d want 1 29", a_wr_en, a_wr_row);
      end
      #2;
      resetn = 1'b0;
      #1;
      total++;
      if ({a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count} !== {1'b0, 1'b1, {RB{1'b0}}, {W{1'b0}}, 16'd0}) begin
         bad++;
         $display("FAIL async_reset got wr_en=%b busy=%b row=%0d data=%h gen=%0d want 0 1 0 0 0",
                  a_wr_en, a_busy, a_wr_row, a_wr_data, a_gen_count);
      end
      cyc(2);
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL async_reset_pending got=%0d want=0", sb_q.size());
      end
      push_clear_seed();
      resetn = 1'b1;
      wait_idle("reset_release");
   endtask

   initial begin
      test_reset();
      test_gen_latency();
      test_frame_count();
      test_blank_stall();
      test_row_wrap();
      test_restart();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
